// File: rtl/bgpu_dispatcher.sv
// Round-robin single-issue dispatcher from per-warp decode slots to the IU/LSU/BRU output registers.
// Latency: grant in cycle N, EU register valid (or illegal pulse) in N+1; warp_ready_o is combinational.
// Backpressure: a warp waits only while its own EU register is full and not draining. Perf counters: BGPU_DISPATCH_PERF_EN.
module bgpu_dispatcher #(
    parameter  int unsigned NumWarps     = 8,
    parameter  int unsigned PayloadWidth = 64,
    parameter  int unsigned CounterWidth = 32,
    localparam int unsigned WidW         = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    localparam int unsigned NumEus       = 3
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NumWarps-1:0]                       warp_valid_i,
    output logic [NumWarps-1:0]                       warp_ready_o,
    input  logic [NumWarps-1:0][7:0]                  warp_inst_i,
    input  logic [NumWarps-1:0][PayloadWidth-1:0]     warp_payload_i,
    output logic [NumEus-1:0]                         eu_valid_o,
    input  logic [NumEus-1:0]                         eu_ready_i,
    output logic [NumEus-1:0][5:0]                    eu_subtype_o,
    output logic [NumEus-1:0][WidW-1:0]               eu_wid_o,
    output logic [NumEus-1:0][PayloadWidth-1:0]       eu_payload_o,
    output logic                                      illegal_o,
    output logic [WidW-1:0]                           illegal_wid_o,
    output logic [NumEus-1:0][CounterWidth-1:0]       perf_dispatch_o,
    output logic [CounterWidth-1:0]                   perf_stall_o
);

    typedef struct packed {
        logic [1:0] eu;
        logic [5:0] subtype;
    } inst_t;

    localparam logic [1:0] EU_BRU   = 2'd2;
    localparam logic [1:0] EU_ILL   = 2'd3;
    localparam logic [5:0] BRU_JMP  = 6'h00;
    localparam logic [5:0] BRU_SYNC = 6'h01;

    inst_t [NumWarps-1:0]               inst;
    logic  [NumWarps-1:0]               illegal;
    logic  [NumWarps-1:0]               cand;
    logic  [NumEus-1:0]                 eu_free;
    logic  [3:0]                        eu_free4;
    logic  [WidW-1:0]                   rr_q;
    logic  [WidW-1:0]                   rr_d;
    logic  [WidW-1:0]                   grant_wid;
    logic                               grant_vld;
    logic                               grant_ill;
    logic  [1:0]                        grant_eu;
    logic  [WidW:0]                     scan_idx;
    logic  [NumEus-1:0]                 eu_load;

    logic  [NumEus-1:0]                 eu_vld_q;
    logic  [NumEus-1:0][5:0]            eu_sub_q;
    logic  [NumEus-1:0][WidW-1:0]       eu_wid_q;
    logic  [NumEus-1:0][PayloadWidth-1:0] eu_pay_q;
    logic                               illegal_q;
    logic  [WidW-1:0]                   illegal_wid_q;

    assign inst     = warp_inst_i;
    assign eu_free  = ~eu_vld_q | eu_ready_i;
    assign eu_free4 = {1'b0, eu_free};

    // Illegal instructions need no EU slot, so they are always eligible.
    always_comb begin
        illegal = '0;
        cand    = '0;
        for (int w = 0; w < NumWarps; w++) begin
            illegal[w] = (inst[w].eu == EU_ILL) ||
                         ((inst[w].eu == EU_BRU) &&
                          ((inst[w].subtype == BRU_JMP) || (inst[w].subtype == BRU_SYNC)));
            cand[w]    = rst_ni && warp_valid_i[w] && (illegal[w] || eu_free4[inst[w].eu]);
        end
    end

    // Scan from the pointer with an explicit wrap so non-power-of-two warp counts stay in range.
    always_comb begin
        grant_vld = 1'b0;
        grant_wid = '0;
        scan_idx  = '0;
        for (int i = 0; i < NumWarps; i++) begin
            scan_idx = {1'b0, rr_q} + (WidW+1)'(i);
            if (scan_idx >= (WidW+1)'(NumWarps)) begin
                scan_idx = scan_idx - (WidW+1)'(NumWarps);
            end
            if (!grant_vld && cand[scan_idx[WidW-1:0]]) begin
                grant_vld = 1'b1;
                grant_wid = scan_idx[WidW-1:0];
            end
        end
    end

    assign grant_ill = illegal[grant_wid];
    assign grant_eu  = inst[grant_wid].eu;

    always_comb begin
        warp_ready_o = '0;
        for (int w = 0; w < NumWarps; w++) begin
            warp_ready_o[w] = grant_vld && (grant_wid == WidW'(w));
        end
    end

    always_comb begin
        eu_load = '0;
        for (int e = 0; e < NumEus; e++) begin
            eu_load[e] = grant_vld && !grant_ill && (grant_eu == 2'(e));
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_vld) begin
            rr_d = (grant_wid == WidW'(NumWarps - 1)) ? '0 : grant_wid + WidW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q          <= '0;
            illegal_q     <= 1'b0;
            illegal_wid_q <= '0;
        end else begin
            rr_q      <= rr_d;
            illegal_q <= grant_vld && grant_ill;
            if (grant_vld && grant_ill) begin
                illegal_wid_q <= grant_wid;
            end
        end
    end

    // A load in the same cycle as a drain keeps the register valid with the new instruction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eu_vld_q <= '0;
            eu_sub_q <= '0;
            eu_wid_q <= '0;
            eu_pay_q <= '0;
        end else begin
            for (int e = 0; e < NumEus; e++) begin
                if (eu_load[e]) begin
                    eu_vld_q[e] <= 1'b1;
                    eu_sub_q[e] <= inst[grant_wid].subtype;
                    eu_wid_q[e] <= grant_wid;
                    eu_pay_q[e] <= warp_payload_i[grant_wid];
                end else if (eu_ready_i[e]) begin
                    eu_vld_q[e] <= 1'b0;
                end
            end
        end
    end

    assign eu_valid_o    = eu_vld_q;
    assign eu_subtype_o  = eu_sub_q;
    assign eu_wid_o      = eu_wid_q;
    assign eu_payload_o  = eu_pay_q;
    assign illegal_o     = illegal_q;
    assign illegal_wid_o = illegal_wid_q;

`ifdef BGPU_DISPATCH_PERF_EN
    logic [NumEus-1:0][CounterWidth-1:0] perf_disp_q;
    logic [CounterWidth-1:0]             perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_disp_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int e = 0; e < NumEus; e++) begin
                if (eu_load[e]) begin
                    perf_disp_q[e] <= perf_disp_q[e] + CounterWidth'(1);
                end
            end
            if ((|warp_valid_i) && !grant_vld) begin
                perf_stall_q <= perf_stall_q + CounterWidth'(1);
            end
        end
    end

    assign perf_dispatch_o = perf_disp_q;
    assign perf_stall_o    = perf_stall_q;
`else
    assign perf_dispatch_o = '0;
    assign perf_stall_o    = '0;
`endif

endmodule

// File: tb/tb_bgpu_dispatcher.sv
// Directed bench for bgpu_dispatcher: arbitration order, EU steering, backpressure, illegal handling, reset.
module tb_bgpu_dispatcher;

`ifdef BGPU_DISPATCH_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [7:0]       warp_valid;
    logic [7:0]       warp_ready;
    logic [7:0][7:0]  warp_inst;
    logic [7:0][63:0] warp_payload;
    logic [2:0]       eu_valid;
    logic [2:0]       eu_ready;
    logic [2:0][5:0]  eu_subtype;
    logic [2:0][2:0]  eu_wid;
    logic [2:0][63:0] eu_payload;
    logic             illegal;
    logic [2:0]       illegal_wid;
    logic [2:0][31:0] perf_dispatch;
    logic [31:0]      perf_stall;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    bgpu_dispatcher #(.NumWarps(8), .PayloadWidth(64), .CounterWidth(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .warp_valid_i    (warp_valid),
        .warp_ready_o    (warp_ready),
        .warp_inst_i     (warp_inst),
        .warp_payload_i  (warp_payload),
        .eu_valid_o      (eu_valid),
        .eu_ready_i      (eu_ready),
        .eu_subtype_o    (eu_subtype),
        .eu_wid_o        (eu_wid),
        .eu_payload_o    (eu_payload),
        .illegal_o       (illegal),
        .illegal_wid_o   (illegal_wid),
        .perf_dispatch_o (perf_dispatch),
        .perf_stall_o    (perf_stall)
    );

    task automatic idle_inputs();
        warp_valid   = '0;
        warp_inst    = '0;
        warp_payload = '0;
        eu_ready     = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic set_warp(input int w, input logic [1:0] eu, input logic [5:0] sub, input logic [63:0] pay);
        warp_valid[w]   = 1'b1;
        warp_inst[w]    = {eu, sub};
        warp_payload[w] = pay;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        for (int w = 0; w < 8; w++) set_warp(w, 2'd0, 6'h05, 64'(w));
        eu_ready = 3'b111;
        #12;
        total_cnt++; if (warp_ready !== 8'h00) $display("FAIL reset_ready: got %h want 00", warp_ready); else pass_cnt++;
        total_cnt++; if (eu_valid !== 3'b000) $display("FAIL reset_eu_valid: got %b want 000", eu_valid); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0 || illegal_wid !== 3'd0) $display("FAIL reset_illegal: got %b/%0d want 0/0", illegal, illegal_wid); else pass_cnt++;
        total_cnt++; if (eu_payload !== '0 || eu_wid !== '0 || eu_subtype !== '0) $display("FAIL reset_eu_regs: got payload %h wid %h sub %h want 0", eu_payload, eu_wid, eu_subtype); else pass_cnt++;
        total_cnt++; if (perf_stall !== 32'd0 || perf_dispatch !== '0) $display("FAIL reset_perf: got %0d/%h want 0", perf_stall, perf_dispatch); else pass_cnt++;
    endtask

    task automatic test_fairness();
        int exp;
        apply_reset();
        for (int w = 0; w < 8; w++) set_warp(w, 2'd0, 6'h05, 64'(w));
        eu_ready = 3'b001;
        for (int k = 0; k < 9; k++) begin
            exp = k % 8;
            #1;
            total_cnt++; if (warp_ready !== 8'(1 << exp)) $display("FAIL fair_grant%0d: got %h want %h", k, warp_ready, 8'(1 << exp)); else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (eu_valid[0] !== 1'b1 || eu_wid[0] !== 3'(exp) || eu_payload[0] !== 64'(exp))
                $display("FAIL fair_iu%0d: got v%b wid %0d pay %h want v1 wid %0d pay %h", k, eu_valid[0], eu_wid[0], eu_payload[0], exp, exp);
            else pass_cnt++;
        end
        idle_inputs();
        eu_ready = 3'b111;
        @(negedge clk);
        total_cnt++; if (eu_valid !== 3'b000) $display("FAIL fair_drain: got %b want 000", eu_valid); else pass_cnt++;
    endtask

    task automatic test_single_iu();
        apply_reset();
        set_warp(3, 2'd0, 6'h05, 64'hAB);
        #1;
        total_cnt++; if (warp_ready !== 8'h08) $display("FAIL single_ready: got %h want 08", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (eu_valid !== 3'b001 || eu_subtype[0] !== 6'h05 || eu_wid[0] !== 3'd3 || eu_payload[0] !== 64'hAB)
            $display("FAIL single_iu_out: got v%b sub %h wid %0d pay %h want v001 sub 05 wid 3 pay ab", eu_valid, eu_subtype[0], eu_wid[0], eu_payload[0]);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] stall0;
        apply_reset();
        set_warp(2, 2'd1, 6'h02, 64'h11);
        #1;
        total_cnt++; if (warp_ready !== 8'h04) $display("FAIL bp_fill_ready: got %h want 04", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (eu_valid !== 3'b010 || eu_wid[1] !== 3'd2) $display("FAIL bp_fill_lsu: got v%b wid %0d want v010 wid 2", eu_valid, eu_wid[1]); else pass_cnt++;
        warp_valid = '0;
        set_warp(0, 2'd1, 6'h02, 64'h22);
        set_warp(1, 2'd0, 6'h06, 64'h33);
        stall0 = perf_stall;
        #1;
        total_cnt++; if (warp_ready !== 8'h02) $display("FAIL bp_skip_blocked: got %h want 02", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (eu_valid !== 3'b011 || eu_wid[0] !== 3'd1 || eu_wid[1] !== 3'd2 || eu_payload[1] !== 64'h11)
            $display("FAIL bp_state: got v%b wid0 %0d wid1 %0d pay1 %h want v011 1 2 11", eu_valid, eu_wid[0], eu_wid[1], eu_payload[1]);
        else pass_cnt++;
        total_cnt++; if (perf_stall !== stall0) $display("FAIL bp_no_stall: got %0d want %0d", perf_stall, stall0); else pass_cnt++;
        warp_valid[1] = 1'b0;
        #1;
        total_cnt++; if (warp_ready !== 8'h00) $display("FAIL bp_blocked: got %h want 00", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (perf_stall !== stall0 + 32'(PerfEn)) $display("FAIL bp_stall_count: got %0d want %0d", perf_stall, stall0 + 32'(PerfEn)); else pass_cnt++;
        eu_ready[1] = 1'b1;
        #1;
        total_cnt++; if (warp_ready !== 8'h01) $display("FAIL bp_release: got %h want 01", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (eu_valid !== 3'b011 || eu_wid[1] !== 3'd0 || eu_payload[1] !== 64'h22)
            $display("FAIL bp_reload_lsu: got v%b wid %0d pay %h want v011 wid 0 pay 22", eu_valid, eu_wid[1], eu_payload[1]);
        else pass_cnt++;
        total_cnt++;
        if (perf_dispatch[0] !== 32'(PerfEn) || perf_dispatch[1] !== 32'(2 * PerfEn))
            $display("FAIL bp_dispatch_count: got %0d/%0d want %0d/%0d", perf_dispatch[0], perf_dispatch[1], PerfEn, 2 * PerfEn);
        else pass_cnt++;
        idle_inputs();
        eu_ready = 3'b111;
        @(negedge clk);
        total_cnt++; if (eu_valid !== 3'b000) $display("FAIL bp_drain: got %b want 000", eu_valid); else pass_cnt++;
    endtask

    task automatic test_illegal();
        idle_inputs();
        set_warp(5, 2'd2, 6'h01, 64'h55);
        #1;
        total_cnt++; if (warp_ready !== 8'h20) $display("FAIL ill_sync_ready: got %h want 20", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (illegal !== 1'b1 || illegal_wid !== 3'd5 || eu_valid !== 3'b000)
            $display("FAIL ill_sync_pulse: got ill %b wid %0d v%b want 1 5 000", illegal, illegal_wid, eu_valid);
        else pass_cnt++;
        warp_valid = '0;
        set_warp(6, 2'd3, 6'h10, 64'h66);
        #1;
        total_cnt++; if (warp_ready !== 8'h40) $display("FAIL ill_eu3_ready: got %h want 40", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (illegal !== 1'b1 || illegal_wid !== 3'd6 || eu_valid !== 3'b000)
            $display("FAIL ill_eu3_pulse: got ill %b wid %0d v%b want 1 6 000", illegal, illegal_wid, eu_valid);
        else pass_cnt++;
        warp_valid = '0;
        @(negedge clk);
        total_cnt++; if (illegal !== 1'b0) $display("FAIL ill_one_cycle: got %b want 0", illegal); else pass_cnt++;
    endtask

    task automatic test_drain_reload();
        idle_inputs();
        set_warp(4, 2'd2, 6'h02, 64'h44);
        #1;
        total_cnt++; if (warp_ready !== 8'h10) $display("FAIL dr_first_ready: got %h want 10", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (eu_valid[2] !== 1'b1 || eu_wid[2] !== 3'd4) $display("FAIL dr_first: got v%b wid %0d want v1 wid 4", eu_valid[2], eu_wid[2]); else pass_cnt++;
        warp_valid = '0;
        set_warp(7, 2'd2, 6'h02, 64'h77);
        eu_ready[2] = 1'b1;
        #1;
        total_cnt++; if (warp_ready !== 8'h80) $display("FAIL dr_reload_ready: got %h want 80", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (eu_valid[2] !== 1'b1 || eu_wid[2] !== 3'd7 || eu_payload[2] !== 64'h77 || eu_subtype[2] !== 6'h02)
            $display("FAIL dr_reload: got v%b wid %0d pay %h sub %h want v1 wid 7 pay 77 sub 02", eu_valid[2], eu_wid[2], eu_payload[2], eu_subtype[2]);
        else pass_cnt++;
        warp_valid = '0;
        @(negedge clk);
        total_cnt++; if (eu_valid[2] !== 1'b0) $display("FAIL dr_clear: got %b want 0", eu_valid[2]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_warp(0, 2'd0, 6'h05, 64'h01);
        set_warp(1, 2'd1, 6'h02, 64'h02);
        set_warp(2, 2'd2, 6'h02, 64'h03);
        repeat (3) @(negedge clk);
        total_cnt++; if (eu_valid !== 3'b111) $display("FAIL rm_full: got %b want 111", eu_valid); else pass_cnt++;
        rst_ni = 1'b0;
        #1;
        total_cnt++; if (eu_valid !== 3'b000 || warp_ready !== 8'h00) $display("FAIL rm_async_clear: got v%b rdy %h want 000 00", eu_valid, warp_ready); else pass_cnt++;
        total_cnt++; if (perf_stall !== 32'd0 || perf_dispatch !== '0) $display("FAIL rm_perf_clear: got %0d/%h want 0", perf_stall, perf_dispatch); else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        set_warp(1, 2'd0, 6'h05, 64'hA1);
        set_warp(5, 2'd0, 6'h05, 64'hA5);
        eu_ready = 3'b111;
        rst_ni = 1'b1;
        #1;
        total_cnt++; if (warp_ready !== 8'h02) $display("FAIL rm_scan_from0: got %h want 02", warp_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (eu_valid[0] !== 1'b1 || eu_wid[0] !== 3'd1) $display("FAIL rm_first_out: got v%b wid %0d want v1 wid 1", eu_valid[0], eu_wid[0]); else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_iu();
        test_backpressure();
        test_illegal();
        test_drain_reload();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
